// File: rtl/piso_serializer_pkg.sv
// Shared constants and helpers for the multi-lane PISO serializer.
package piso_serializer_pkg;

  localparam logic SHIFT_MSB_FIRST = 1'b1;
  localparam logic SHIFT_LSB_FIRST = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/piso_serializer_lane.sv
// One lane shift register: parallel load with priority over a single-bit shift
// in either direction, refilling the vacated end from fill_in.
module piso_lane
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock_in,
  input  logic             n_reset_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_in,
  input  logic             dir_in,
  input  logic             fill_in,
  output logic             msb_out,
  output logic             lsb_out
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_in) begin
      shreg_d = data_in;
    end else if (shift_in) begin
      if (dir_in == SHIFT_MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], fill_in};
      else                           shreg_d = {fill_in, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock_in or negedge n_reset_in) begin
    if (!n_reset_in) shreg_q <= '0;
    else             shreg_q <= shreg_d;
  end

  assign msb_out = shreg_q[WIDTH-1];
  assign lsb_out = shreg_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Multi-lane parallel-to-serial converter: valid/ready input, one-word holding
// buffer, per-word length and bit order, gapless back-to-back words.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter  int   WIDTH = 8,
  parameter  int   LANES = 1,
  parameter  logic IDLE  = 1'b0,
  localparam int   CNT_W = clog2(WIDTH + 1)
) (
  input  logic                   clock_in,
  input  logic                   n_reset_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [LANES*WIDTH-1:0] pdata_in,
  input  logic [CNT_W-1:0]       len_in,
  input  logic                   msb_first_in,
  input  logic                   shift_in,
  input  logic                   fill_in,
  input  logic                   abort_in,
  output logic [LANES-1:0]       sdata_out,
  output logic                   busy_out,
  output logic                   last_out,
  output logic                   done_out
);

  logic                   hold_valid_q, hold_valid_d;
  logic [LANES*WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]       hold_len_q, hold_len_d;
  logic                   hold_dir_q, hold_dir_d;
  logic                   active_q, active_d;
  logic [CNT_W-1:0]       remaining_q, remaining_d;
  logic                   dir_q, dir_d;
  logic                   done_q, done_d;

  logic             last;
  logic             load;
  logic             accept;
  logic             shift_en;
  logic [CNT_W-1:0] eff_len;
  logic [LANES-1:0] lane_msb;
  logic [LANES-1:0] lane_lsb;

  assign last     = active_q && (remaining_q == CNT_W'(1));
  assign load     = !abort_in && hold_valid_q && (!active_q || (shift_in && last));
  assign accept   = !abort_in && valid_in && !hold_valid_q;
  assign shift_en = !abort_in && shift_in && active_q && !load;
  assign eff_len  = ((hold_len_q == '0) || (hold_len_q > CNT_W'(WIDTH))) ? CNT_W'(WIDTH)
                                                                         : hold_len_q;

  // Abort wins over everything; the final shift of one word and the load of
  // the next share an edge so the stream has no idle bit between words.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_len_d   = hold_len_q;
    hold_dir_d   = hold_dir_q;
    active_d     = active_q;
    remaining_d  = remaining_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    if (abort_in) begin
      hold_valid_d = 1'b0;
      active_d     = 1'b0;
      remaining_d  = '0;
    end else begin
      done_d = shift_in && last;
      if (load) begin
        hold_valid_d = 1'b0;
        active_d     = 1'b1;
        remaining_d  = eff_len;
        dir_d        = hold_dir_q;
      end else if (shift_in && active_q) begin
        remaining_d = remaining_q - CNT_W'(1);
        active_d    = (remaining_q != CNT_W'(1));
      end
      if (accept) begin
        hold_valid_d = 1'b1;
        hold_data_d  = pdata_in;
        hold_len_d   = len_in;
        hold_dir_d   = msb_first_in;
      end
    end
  end

  always_ff @(posedge clock_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_len_q   <= '0;
      hold_dir_q   <= SHIFT_MSB_FIRST;
      active_q     <= 1'b0;
      remaining_q  <= '0;
      dir_q        <= SHIFT_MSB_FIRST;
      done_q       <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_len_q   <= hold_len_d;
      hold_dir_q   <= hold_dir_d;
      active_q     <= active_d;
      remaining_q  <= remaining_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    piso_lane #(.WIDTH(WIDTH)) u_lane (
      .clock_in   (clock_in),
      .n_reset_in (n_reset_in),
      .load_in    (load),
      .data_in    (hold_data_q[k*WIDTH +: WIDTH]),
      .shift_in   (shift_en),
      .dir_in     (hold_dir_q & load | dir_q & !load),
      .fill_in    (fill_in),
      .msb_out    (lane_msb[k]),
      .lsb_out    (lane_lsb[k])
    );
    assign sdata_out[k] = active_q ? ((dir_q == SHIFT_LSB_FIRST) ? lane_lsb[k] : lane_msb[k])
                                   : IDLE;
  end

  assign ready_out = !hold_valid_q;
  assign busy_out  = active_q;
  assign last_out  = last;
  assign done_out  = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer with WIDTH=8, LANES=2: words pushed by
// the stimulus enqueue their expected bit stream, a monitor pops per shifted bit.
module tb_piso_serializer;

  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int CNT_W = 4;

  logic                   clock_in     = 1'b0;
  logic                   n_reset_in   = 1'b0;
  logic                   valid_in     = 1'b0;
  logic                   ready_out;
  logic [LANES*WIDTH-1:0] pdata_in     = '0;
  logic [CNT_W-1:0]       len_in       = '0;
  logic                   msb_first_in = 1'b1;
  logic                   shift_in     = 1'b0;
  logic                   fill_in      = 1'b0;
  logic                   abort_in     = 1'b0;
  logic [LANES-1:0]       sdata_out;
  logic                   busy_out;
  logic                   last_out;
  logic                   done_out;

  // Each entry is {lane bits, last flag} for one serialized bit period.
  typedef logic [LANES:0] exp_t;
  exp_t exp_q[$];

  int   assert_count = 0;
  int   fail_count   = 0;
  int   done_count   = 0;
  int   gap_count    = 0;
  logic gap_window   = 1'b0;
  int   start_done;

  piso_serializer #(.WIDTH(WIDTH), .LANES(LANES), .IDLE(1'b0)) dut (
    .clock_in     (clock_in),
    .n_reset_in   (n_reset_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .pdata_in     (pdata_in),
    .len_in       (len_in),
    .msb_first_in (msb_first_in),
    .shift_in     (shift_in),
    .fill_in      (fill_in),
    .abort_in     (abort_in),
    .sdata_out    (sdata_out),
    .busy_out     (busy_out),
    .last_out     (last_out),
    .done_out     (done_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock_in) begin
    exp_t e;
    if (n_reset_in) begin
      if (gap_window && exp_q.size() > 0 && !busy_out) gap_count++;
      if (done_out) done_count++;
      if (shift_in && busy_out) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_bit", {29'd0, sdata_out, last_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_output("serial_bit", {29'd0, sdata_out, last_out}, {29'd0, e});
        end
      end
    end
  end

  task automatic sync_drive();
    @(posedge clock_in);
    #1;
  endtask

  // Enqueue the expected bit stream, then offer the word until accepted.
  task automatic apply_stimulus(input logic [15:0] data, input logic [3:0] len,
                                input logic msb);
    int   eff;
    int   idx;
    exp_t e;
    logic ok;
    eff = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
    for (int b = 0; b < eff; b++) begin
      for (int k = 0; k < LANES; k++) begin
        idx = msb ? (WIDTH - 1 - b) : b;
        e[k+1] = data[k*WIDTH + idx];
      end
      e[0] = (b == eff - 1);
      exp_q.push_back(e);
    end
    pdata_in     = data;
    len_in       = len;
    msb_first_in = msb;
    valid_in     = 1'b1;
    ok           = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock_in);
      if (ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) sync_drive();
    valid_in = 1'b0;
    check_output("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic strobe_shifts(input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      shift_in = 1'b1;
      sync_drive();
      shift_in = 1'b0;
      for (int g = 0; g < gap; g++) sync_drive();
    end
  endtask

  task automatic wait_busy(input int budget);
    for (int t = 0; t < budget; t++) begin
      @(negedge clock_in);
      if (busy_out) break;
    end
    check_output("busy_wait", {31'd0, busy_out}, 32'd1);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int t = 0; t < budget; t++) begin
      @(negedge clock_in);
      #1;
      if (done_count >= target) break;
    end
    check_output("done_wait", done_count, target);
  endtask

  task automatic check_idle(input string name);
    check_output({name, "_sdata"}, {30'd0, sdata_out}, 32'd0);
    check_output({name, "_busy"},  {31'd0, busy_out},  32'd0);
    check_output({name, "_last"},  {31'd0, last_out},  32'd0);
    check_output({name, "_done"},  {31'd0, done_out},  32'd0);
    check_output({name, "_ready"}, {31'd0, ready_out}, 32'd1);
  endtask

  initial begin
    // Reset state, then release between edges.
    #12;
    check_idle("reset");
    n_reset_in = 1'b1;
    sync_drive();

    // 1: A5 msb-first full length, slow strobe.
    $display("[TB] test 1: msb-first full word");
    start_done = done_count;
    apply_stimulus(16'h3CA5, 4'd0, 1'b1);
    wait_busy(20);
    sync_drive();
    strobe_shifts(8, 3);
    check_output("t1_done_pulses", done_count, start_done + 1);
    check_idle("t1_after");

    // 2: same word lsb-first, 3 bits.
    $display("[TB] test 2: lsb-first len 3");
    start_done = done_count;
    apply_stimulus(16'h3CA5, 4'd3, 1'b0);
    wait_busy(20);
    sync_drive();
    strobe_shifts(3, 3);
    check_output("t2_done_pulses", done_count, start_done + 1);
    check_idle("t2_after");

    // 3: back-to-back words with shift_in held high.
    $display("[TB] test 3: back-to-back stream");
    start_done = done_count;
    gap_count  = 0;
    shift_in   = 1'b1;
    apply_stimulus(16'h81FF, 4'd0, 1'b1);
    sync_drive();
    gap_window = 1'b1;
    apply_stimulus(16'h7E00, 4'd0, 1'b1);
    @(negedge clock_in);
    check_output("t3_ready_hold_full", {31'd0, ready_out}, 32'd0);
    wait_done(start_done + 2, 40);
    shift_in   = 1'b0;
    gap_window = 1'b0;
    check_output("t3_busy_gaps", gap_count, 0);
    sync_drive();
    sync_drive();
    check_output("t3_done_pulses", done_count, start_done + 2);

    // 4: two lanes, oversized length clamps to the full word.
    $display("[TB] test 4: two lanes, len 9");
    start_done = done_count;
    apply_stimulus(16'h0FF0, 4'd9, 1'b1);
    wait_busy(20);
    sync_drive();
    strobe_shifts(8, 1);
    check_output("t4_done_pulses", done_count, start_done + 1);

    // 5: abort after 3 bits with the holding buffer full.
    $display("[TB] test 5: abort");
    start_done = done_count;
    apply_stimulus(16'hA5A5, 4'd0, 1'b1);
    apply_stimulus(16'h1234, 4'd0, 1'b1);
    strobe_shifts(3, 0);
    check_output("t5_ready_before", {31'd0, ready_out}, 32'd0);
    abort_in = 1'b1;
    sync_drive();
    abort_in = 1'b0;
    exp_q.delete();
    @(negedge clock_in);
    check_idle("t5_abort");
    repeat (4) @(negedge clock_in);
    #1;
    check_output("t5_no_done", done_count, start_done);

    // 6: async reset mid-word, asserted and released between edges.
    $display("[TB] test 6: async reset mid-word");
    sync_drive();
    apply_stimulus(16'h5AC3, 4'd0, 1'b1);
    apply_stimulus(16'hFFFF, 4'd0, 1'b0);
    strobe_shifts(2, 0);
    #2;
    n_reset_in = 1'b0;
    #1;
    check_idle("t6_reset");
    exp_q.delete();
    #12;
    n_reset_in = 1'b1;
    sync_drive();
    start_done = done_count;
    apply_stimulus(16'h81C3, 4'd0, 1'b1);
    wait_busy(20);
    sync_drive();
    strobe_shifts(8, 1);
    check_output("t6_done_pulses", done_count, start_done + 1);

    check_output("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
